// File: rtl/mont_mul_iter.sv
// mont_mul_iter: iterative radix-2 Montgomery multiplier, result = a*b*2^-WIDTH mod n.
// One bit of a per cycle, a final conditional subtract, and err for an even modulus.
module mont_mul_iter #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, n_q, result_q;
    logic [WIDTH+1:0] s_q, s1, s2, s_d, diff;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, err_q;
    logic [WIDTH-1:0] res_fix;
    // Two extra bits keep S + b + n below 2^(WIDTH+2) because S stays under 2n.
    always_comb begin
        s1      = s_q + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        s2      = s1 + (s1[0] ? {2'b00, n_q} : '0);
        s_d     = s2 >> 1;
        diff    = s_q - {2'b00, n_q};
        res_fix = (s_q >= {2'b00, n_q}) ? diff[WIDTH-1:0] : s_q[WIDTH-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    n_q   <= n;
                    s_q   <= '0;
                    cnt_q <= '0;
                    err_q <= ~n[0];
                    if (n[0]) begin
                        state_q <= ITER;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= '0;
                    end
                end
                ITER: begin
                    s_q   <= s_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    result_q <= res_fix;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
endmodule
